mdu_iter: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage, downstream of the instruction decoder.
- Executes the R6 MUL/MUH/MULU/MUHU/DIV/MOD/DIVU/MODU operations that the single-cycle ALU does not handle.
- EX glue maps the decoder's ALU_OP_* codes to the local 3-bit `op` and holds the pipeline stalled while `busy` is high.
- Iterative radix-2 datapath, 32 compute cycles per operation, start/busy/done handshake.

---
 rtl/mdu_iter.sv | 106 ++++++++++
 tb/tb_mdu_iter.sv | 114 +++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide unit with start/busy/done handshake
// Define MDU_FAST_MUL_EN for single-cycle combinational multiplies.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic               neg_p, neg_r, bz;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_in, b_in;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quo, rem, fix_res;
  assign a_neg    = ~op[1] & src_a[WIDTH-1];
  assign b_neg    = ~op[1] & src_b[WIDTH-1];
  assign a_in     = a_neg ? -src_a : src_a;
  assign b_in     = b_neg ? -src_b : src_b;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, b_mag};
  // rem_sh < b_mag whenever the subtraction borrows, so its MSB is zero there
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign quo      = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];
  assign prod     = neg_p ? -acc : acc;
  assign fix_res  = op_q[1] ? (op_q[0] ? (neg_r ? -rem : rem) : (bz ? '1 : (neg_p ? -quo : quo)))
                            : (op_q[0] ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0]);
  assign busy     = state != IDLE;
`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fprod;
  assign ext_a = {{WIDTH{a_neg}}, src_a};
  assign ext_b = {{WIDTH{b_neg}}, src_b};
  assign fprod = ext_a * ext_b;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      b_mag    <= '0;
      acc      <= '0;
      neg_p    <= 1'b0;
      neg_r    <= 1'b0;
      bz       <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kill) state <= IDLE;
      else case (state)
        IDLE: if (start) begin
`ifdef MDU_FAST_MUL_EN
          if (!op[2]) begin
            result   <= op[0] ? fprod[2*WIDTH-1:WIDTH] : fprod[WIDTH-1:0];
            div_zero <= 1'b0;
            done     <= 1'b1;
          end else
`endif
          begin
            state <= CALC;
            cnt   <= '0;
            op_q  <= {op[2], op[0]};
            b_mag <= b_in;
            acc   <= {{WIDTH{1'b0}}, a_in};
            neg_p <= a_neg ^ b_neg;
            neg_r <= a_neg;
            bz    <= src_b == '0;
          end
        end
        CALC: begin
          acc <= op_q[1] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          result   <= fix_res;
          div_zero <= op_q[1] & bz;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed checks of mdu_iter timing, results, kill and reset
module tb_mdu_iter;
  localparam logic [2:0] MUL = 3'd0, MUH = 3'd1, MULU = 3'd2, MUHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, MOD = 3'd5, DIVU = 3'd6, MODU = 3'd7;
`ifdef MDU_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 34;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, kill = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] result;
  logic [31:0] last_res = '0;
  int total = 0, bad = 0;
  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .result(result), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input logic dz, input int lat);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      start = 1'b0; src_a = 32'hdead_beef; src_b = 32'h5a5a_5a5a;
      if (c < lat) begin
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
      end else begin
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_dz"}, {31'd0, div_zero}, {31'd0, dz});
      end
    end
    last_res = exp;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    rst_n = 1'b1;
    run("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34);
    run("mod_m7_2", MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
    run("mul_ff", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ML);
    run("mulu_ff", MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ML);
    run("muhu_ff", MUHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, ML);
    run("muh_ff", MUH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, ML);
    run("mul_7_m3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, ML);
    run("muh_7_m3", MUH, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, ML);
    run("muhu_big", MUHU, 32'h8000_0000, 32'd4, 32'h0000_0002, 1'b0, ML);
    run("divu_z", DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b1, 34);
    run("modu_z", MODU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1, 34);
    run("mod_negz", MOD, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 1'b1, 34);
    run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34);
    run("mod_ovf", MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 34);
    run("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34);
    // start/kill sequence: cycle 0 start, cycle 5 stray start, cycle 10 kill
    @(negedge clk);
    op = DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      if (c <= 10) chk("kill_busy", {31'd0, busy}, 32'd1);
      else chk("kill_idle", {31'd0, busy}, 32'd0);
      chk("kill_nodone", {31'd0, done}, 32'd0);
      if (c == 5) begin op = MODU; src_a = 32'd9; src_b = 32'd2; start = 1'b1; end
      if (c == 10) kill = 1'b1;
    end
    chk("kill_res_held", result, last_res);
    run("restart", DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34);
    // reset mid-operation after a nonzero result and div_zero
    run("pre_rst", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 34);
    @(negedge clk);
    op = DIV; src_a = 32'd50; src_b = 32'd3; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("prerst_busy", {31'd0, busy}, 32'd1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_res", result, 32'd0);
    chk("mrst_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    op = MULU; src_a = 32'd3; src_b = 32'd3; start = 1'b1; kill = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      chk("sk_busy", {31'd0, busy}, 32'd0);
      chk("sk_done", {31'd0, done}, 32'd0);
    end
    chk("sk_res", result, 32'd0);
    run("after_sk", MODU, 32'd100, 32'd7, 32'd2, 1'b0, 34);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
